rc5_key_expansion: RTL and testbench

RC5-32/12/16 key scheduler. It expands a 128-bit user key into the 26-word subkey table S[0..25] used by the RC5 cipher stages.
- The table is exposed through a registered read port.
- rc5_decryption-class consumers index S[2..25] as their round keys; S[0], S[1] serve the final whitening step.
- The table replaces a hard-coded constant ROM, so keys can change at run time.

---
 rtl/rc5_key_expansion.sv | 165 ++++++++++++++++
 tb/tb_rc5_key_expansion.sv | 372 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_key_expansion.sv
// RC5-32/12/16 key scheduler: expands a 128-bit user key into the 26-word
// subkey table S[0..25] and serves it through a registered read port.
//
// Ports:
//   i_clk          rising-edge clock
//   i_rst_n        asynchronous active-low reset
//   i_start        one-cycle expansion request; i_key sampled on the same edge
//   i_key          user key, L[j] = i_key[32j+31:32j]
//   o_busy         high while INIT/MIX are running
//   o_done         one-cycle pulse when the table becomes valid
//   o_table_valid  table holds a completed expansion
//   i_sk_addr      subkey read index (0..25; larger reads return 0)
//   o_sk_data      S[i_sk_addr], one cycle after i_sk_addr
module rc5_key_expansion (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [127:0] i_key,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_table_valid,
    input  logic [4:0]   i_sk_addr,
    output logic [31:0]  o_sk_data
);

    localparam int unsigned W         = 32;
    localparam int unsigned T         = 26;
    localparam int unsigned C         = 4;
    localparam int unsigned IW        = 5;
    localparam int unsigned KW        = 7;
    localparam int unsigned MIX_STEPS = 78;

    localparam logic [W-1:0] P32 = 32'hB7E15163;
    localparam logic [W-1:0] Q32 = 32'h9E3779B9;

    typedef enum logic [1:0] {
        S_IDLE,
        S_INIT,
        S_MIX,
        S_DONE
    } state_t;

    state_t          r_state;
    logic [W-1:0]    r_s [0:T-1];
    logic [W-1:0]    r_l [0:C-1];
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_init_val;
    logic [IW-1:0]   r_i;
    logic [1:0]      r_j;
    logic [KW-1:0]   r_k;

    logic [W-1:0]    w_s_cur;
    logic [W-1:0]    w_l_cur;
    logic [W-1:0]    w_a_new;
    logic [W-1:0]    w_ab;
    logic [W-1:0]    w_b_new;
    logic [IW-1:0]   w_i_next;
    logic            w_s_we;
    logic [W-1:0]    w_s_wdata;

    // Rotate via a doubled word so a zero amount returns the operand unchanged.
    function automatic logic [W-1:0] rotl32(input logic [W-1:0] x, input logic [IW-1:0] s);
        logic [2*W-1:0] w_dbl;
        w_dbl = {x, x} << s;
        return w_dbl[2*W-1:W];
    endfunction

    // One mixing step and the table write port.
    always_comb begin
        w_s_cur   = r_s[r_i];
        w_l_cur   = r_l[r_j];
        w_a_new   = rotl32(w_s_cur + r_a + r_b, IW'(3));
        w_ab      = w_a_new + r_b;
        w_b_new   = rotl32(w_l_cur + w_ab, w_ab[IW-1:0]);
        w_i_next  = (r_i == IW'(T - 1)) ? '0 : r_i + IW'(1);
        w_s_we    = (r_state == S_INIT) || (r_state == S_MIX);
        w_s_wdata = (r_state == S_INIT) ? r_init_val : w_a_new;
    end

    // Subkey table storage; contents are don't-care after reset.
    always_ff @(posedge i_clk) begin
        if (w_s_we) begin
            r_s[r_i] <= w_s_wdata;
        end
    end

    // Control FSM with registered status outputs.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= S_IDLE;
            r_a           <= '0;
            r_b           <= '0;
            r_init_val    <= '0;
            r_i           <= '0;
            r_j           <= '0;
            r_k           <= '0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_table_valid <= 1'b0;
            for (int n = 0; n < int'(C); n++) begin
                r_l[n] <= '0;
            end
        end else begin
            o_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        for (int n = 0; n < int'(C); n++) begin
                            r_l[n] <= i_key[W*n +: W];
                        end
                        r_i           <= '0;
                        r_a           <= '0;
                        r_b           <= '0;
                        r_init_val    <= P32;
                        o_table_valid <= 1'b0;
                        o_busy        <= 1'b1;
                        r_state       <= S_INIT;
                    end
                end
                S_INIT: begin
                    r_init_val <= r_init_val + Q32;
                    r_i        <= w_i_next;
                    if (r_i == IW'(T - 1)) begin
                        r_j     <= '0;
                        r_k     <= '0;
                        r_state <= S_MIX;
                    end
                end
                S_MIX: begin
                    r_l[r_j] <= w_b_new;
                    r_a      <= w_a_new;
                    r_b      <= w_b_new;
                    r_i      <= w_i_next;
                    r_j      <= r_j + 2'd1;
                    r_k      <= r_k + KW'(1);
                    if (r_k == KW'(MIX_STEPS - 1)) begin
                        o_busy        <= 1'b0;
                        o_done        <= 1'b1;
                        o_table_valid <= 1'b1;
                        r_state       <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Registered read port; out-of-range indices read as zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_sk_data <= '0;
        end else if (i_sk_addr < IW'(T)) begin
            o_sk_data <= r_s[i_sk_addr];
        end else begin
            o_sk_data <= '0;
        end
    end

endmodule

// File: tb/tb_rc5_key_expansion.sv
// Self-checking bench for rc5_key_expansion against a plain software RC5 model.
module tb_rc5_key_expansion;

    localparam logic [31:0] P32 = 32'hB7E15163;
    localparam logic [31:0] Q32 = 32'h9E3779B9;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [127:0] key;
    logic         busy;
    logic         done;
    logic         table_valid;
    logic [4:0]   sk_addr;
    logic [31:0]  sk_data;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [31:0] mdl_s [26];
    logic [31:0] dut_s [26];

    rc5_key_expansion u_dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_start       (start),
        .i_key         (key),
        .o_busy        (busy),
        .o_done        (done),
        .o_table_valid (table_valid),
        .i_sk_addr     (sk_addr),
        .o_sk_data     (sk_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [31:0] rol(input logic [31:0] x, input int s);
        int r;
        r = s % 32;
        if (r == 0) return x;
        return (x << r) | (x >> (32 - r));
    endfunction

    function automatic logic [31:0] ror(input logic [31:0] x, input int s);
        int r;
        r = s % 32;
        if (r == 0) return x;
        return (x >> r) | (x << (32 - r));
    endfunction

    // Textbook RC5 key schedule into mdl_s.
    function automatic void model_expand(input logic [127:0] k);
        logic [31:0] l [4];
        logic [31:0] a, b, t;
        int i, j;
        for (int n = 0; n < 4; n++) l[n] = k[32*n +: 32];
        mdl_s[0] = P32;
        for (int n = 1; n < 26; n++) mdl_s[n] = mdl_s[n-1] + Q32;
        a = 0; b = 0; i = 0; j = 0;
        for (int n = 0; n < 78; n++) begin
            a        = rol(mdl_s[i] + a + b, 3);
            mdl_s[i] = a;
            t        = a + b;
            b        = rol(l[j] + t, int'(t[4:0]));
            l[j]     = b;
            i        = (i + 1) % 26;
            j        = (j + 1) % 4;
        end
    endfunction

    function automatic logic [63:0] encrypt(input logic [31:0] s [26], input logic [63:0] pt);
        logic [31:0] a, b;
        a = pt[63:32] + s[0];
        b = pt[31:0] + s[1];
        for (int r = 1; r <= 12; r++) begin
            a = rol(a ^ b, int'(b[4:0])) + s[2*r];
            b = rol(b ^ a, int'(a[4:0])) + s[2*r+1];
        end
        return {a, b};
    endfunction

    function automatic logic [63:0] decrypt(input logic [31:0] s [26], input logic [63:0] ct);
        logic [31:0] a, b;
        a = ct[63:32];
        b = ct[31:0];
        for (int r = 12; r >= 1; r--) begin
            b = ror(b - s[2*r+1], int'(a[4:0])) ^ a;
            a = ror(a - s[2*r], int'(b[4:0])) ^ b;
        end
        return {a - s[0], b - s[1]};
    endfunction

    function automatic logic [127:0] rand_key();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Pulse start and count cycles until done (-1 on timeout).
    task automatic start_and_wait(input logic [127:0] k, output int cycles);
        @(negedge clk);
        start  = 1'b1;
        key    = k;
        cycles = 0;
        do begin
            @(negedge clk);
            start = 1'b0;
            cycles++;
        end while (!done && cycles < 400);
        if (!done) cycles = -1;
    endtask

    task automatic read_table();
        for (int a = 0; a < 26; a++) begin
            @(negedge clk);
            sk_addr = 5'(a);
            @(negedge clk);
            dut_s[a] = sk_data;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        key = '0;
        sk_addr = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, done, table_valid} !== 3'b000 || sk_data !== 32'd0) begin
                errors++;
                $display("FAIL reset_idle cyc%0d: busy=%b done=%b tv=%b sk=%h, need 0 0 0 0",
                         c, busy, done, table_valid, sk_data);
            end
        end
    endtask

    task automatic test_zero_key();
        int cycles;
        logic [63:0] ct;
        start_and_wait('0, cycles);
        checks++;
        if (cycles !== 105) begin
            errors++;
            $display("FAIL zero_latency: got %0d cycles, need 105", cycles);
        end
        checks++;
        if (table_valid !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL zero_status: tv=%b busy=%b, need 1 0", table_valid, busy);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL done_pulse_width: done=%b one cycle later, need 0", done);
        end
        model_expand('0);
        read_table();
        for (int a = 0; a < 26; a++) begin
            checks++;
            if (dut_s[a] !== mdl_s[a]) begin
                errors++;
                $display("FAIL zero_table S[%0d]: got %h, need %h", a, dut_s[a], mdl_s[a]);
            end
        end
        ct = encrypt(dut_s, 64'd0);
        checks++;
        if (ct !== {32'hEEDBA521, 32'h6D8F4B15}) begin
            errors++;
            $display("FAIL zero_vector: ct=%h, need eedba5216d8f4b15", ct);
        end
    endtask

    // 50 back-to-back expansions; the table is read out in the window between
    // done and the first INIT overwrite of each slot.
    task automatic test_random_b2b();
        logic [127:0] keys [50];
        int cnt, last_done;
        for (int n = 0; n < 50; n++) keys[n] = rand_key();
        last_done = 0;
        @(negedge clk);
        start = 1'b1;
        key   = keys[0];
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < 50; n++) begin
            cnt = 0;
            while (!done && cnt < 400) begin
                @(negedge clk);
                cnt++;
            end
            checks++;
            if (!done) begin
                errors++;
                $display("FAIL b2b_timeout key%0d: no done in %0d cycles", n, cnt);
                return;
            end
            if (n > 0) begin
                checks++;
                if (cyc - last_done !== 106) begin
                    errors++;
                    $display("FAIL b2b_spacing key%0d: got %0d cycles, need 106", n, cyc - last_done);
                end
            end
            last_done = cyc;
            for (int t = 0; t <= 26; t++) begin
                if (t > 0) dut_s[t-1] = sk_data;
                if (t < 26) sk_addr = 5'(t);
                start = (t == 1 && n < 49);
                if (t == 1 && n < 49) key = keys[n+1];
                if (t < 26) @(negedge clk);
            end
            start = 1'b0;
            model_expand(keys[n]);
            for (int a = 0; a < 26; a++) begin
                checks++;
                if (dut_s[a] !== mdl_s[a]) begin
                    errors++;
                    $display("FAIL b2b_table key%0d S[%0d]: got %h, need %h", n, a, dut_s[a], mdl_s[a]);
                end
            end
            if (n < 49) @(negedge clk);
        end
    endtask

    task automatic test_start_during_busy();
        logic [127:0] k1, k2;
        int ndone, first_done;
        k1 = rand_key();
        k2 = ~k1;
        ndone = 0;
        first_done = 0;
        @(negedge clk);
        start = 1'b1;
        key   = k1;
        for (int c = 1; c <= 220; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 40) begin
                start = 1'b1;
                key   = k2;
            end
            if (done) begin
                ndone++;
                if (first_done == 0) first_done = c;
            end
        end
        checks++;
        if (ndone !== 1 || first_done !== 105) begin
            errors++;
            $display("FAIL busy_start: %0d done pulses first at %0d, need 1 at 105", ndone, first_done);
        end
        model_expand(k1);
        read_table();
        for (int a = 0; a < 26; a++) begin
            checks++;
            if (dut_s[a] !== mdl_s[a]) begin
                errors++;
                $display("FAIL busy_table S[%0d]: got %h, need %h", a, dut_s[a], mdl_s[a]);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [127:0] k;
        int cycles, ndone;
        @(negedge clk);
        start = 1'b1;
        key   = rand_key();
        @(negedge clk);
        start = 1'b0;
        repeat (59) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL mid_busy: busy=%b before reset, need 1", busy);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || table_valid !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: busy=%b tv=%b done=%b, need 0 0 0", busy, table_valid, done);
        end
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int c = 0; c < 120; c++) begin
            @(negedge clk);
            if (done || busy || table_valid) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL mid_quiet: %0d cycles with activity after reset, need 0", ndone);
        end
        k = rand_key();
        start_and_wait(k, cycles);
        checks++;
        if (cycles !== 105) begin
            errors++;
            $display("FAIL mid_restart: got %0d cycles, need 105", cycles);
        end
        model_expand(k);
        read_table();
        for (int a = 0; a < 26; a++) begin
            checks++;
            if (dut_s[a] !== mdl_s[a]) begin
                errors++;
                $display("FAIL mid_table S[%0d]: got %h, need %h", a, dut_s[a], mdl_s[a]);
            end
        end
    endtask

    // Relies on mdl_s/table from the previous completed expansion.
    task automatic test_read_port();
        logic [63:0] pt, ct, rt;
        for (int a = 26; a < 32; a++) begin
            @(negedge clk);
            sk_addr = 5'(a);
            @(negedge clk);
            checks++;
            if (sk_data !== 32'd0) begin
                errors++;
                $display("FAIL oob_read addr%0d: got %h, need 0", a, sk_data);
            end
        end
        @(negedge clk);
        sk_addr = 5'd3;
        @(negedge clk);
        sk_addr = 5'd2;
        #1;
        checks++;
        if (sk_data !== mdl_s[3]) begin
            errors++;
            $display("FAIL read_hold: got %h, need %h", sk_data, mdl_s[3]);
        end
        @(negedge clk);
        checks++;
        if (sk_data !== mdl_s[2]) begin
            errors++;
            $display("FAIL read_latency: got %h, need %h", sk_data, mdl_s[2]);
        end
        read_table();
        for (int n = 0; n < 4; n++) begin
            pt = {$urandom(), $urandom()};
            ct = encrypt(mdl_s, pt);
            rt = decrypt(dut_s, ct);
            checks++;
            if (rt !== pt) begin
                errors++;
                $display("FAIL decrypt%0d: got %h, need %h", n, rt, pt);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_key();
        test_random_b2b();
        test_start_during_busy();
        test_reset_mid();
        test_read_port();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
